// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write scoreboard for ID-stage issue stalls
module reg_scoreboard #(
    parameter int NUM_REGS = 15,
    parameter int CNT_W    = 2,
    parameter int TOT_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_wb_en,
    input  logic [3:0]          issue_dest,
    input  logic [3:0]          src1,
    input  logic [3:0]          src2,
    input  logic                src1_valid,
    input  logic                src2_valid,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [3:0]          wb_dest,
    output logic                issue_ready,
    output logic                issue_fire,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [TOT_W-1:0]    inflight,
    output logic                err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [CNT_W-1:0]    count [NUM_REGS];
    logic [CNT_W-1:0]    eff   [NUM_REGS];
    logic [NUM_REGS-1:0] ret;
    logic [NUM_REGS-1:0] alloc;
    logic                src1_haz;
    logic                src2_haz;
    logic                sat;
    logic                underflow;

    // Same-cycle view of each counter: a WB retiring this cycle is already
    // written by the negedge register file, so it no longer blocks readers.
    // Index 15 (PC) never matches any loop index, so it is never tracked.
    always_comb begin
        ret       = '0;
        src1_haz  = 1'b0;
        src2_haz  = 1'b0;
        sat       = 1'b0;
        underflow = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            ret[r] = wb_en && (wb_dest == 4'(r)) && (count[r] != CNT_ZERO);
            eff[r] = count[r] - {{(CNT_W-1){1'b0}}, ret[r]};
            if (src1_valid && (src1 == 4'(r)) && (eff[r] != CNT_ZERO))
                src1_haz = 1'b1;
            if (src2_valid && (src2 == 4'(r)) && (eff[r] != CNT_ZERO))
                src2_haz = 1'b1;
            if (issue_wb_en && (issue_dest == 4'(r)) && (eff[r] == CNT_MAX))
                sat = 1'b1;
            if (wb_en && (wb_dest == 4'(r)) && (count[r] == CNT_ZERO))
                underflow = 1'b1;
        end
    end

    // Issue handshake: ready ignores valid/flush so ID can probe it freely.
    always_comb begin
        hazard      = src1_haz || src2_haz;
        issue_ready = !hazard && !sat;
        issue_fire  = issue_valid && issue_ready && !flush;
    end

    // Allocation decode and the registered busy view.
    always_comb begin
        alloc     = '0;
        busy_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            alloc[r]     = issue_fire && issue_wb_en && (issue_dest == 4'(r));
            busy_mask[r] = (count[r] != CNT_ZERO);
        end
    end

    // Counter, total and sticky error state; alloc and retire on the same
    // register in one cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                count[r] <= '0;
            inflight      <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                count[r] <= count[r] + {{(CNT_W-1){1'b0}}, alloc[r]}
                                     - {{(CNT_W-1){1'b0}}, ret[r]};
            inflight <= inflight + {{(TOT_W-1){1'b0}}, |alloc}
                                 - {{(TOT_W-1){1'b0}}, |ret};
            if (underflow)
                err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - table-driven self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid, issue_wb_en, flush, wb_en;
    logic [3:0]  issue_dest, src1, src2, wb_dest;
    logic        src1_valid, src2_valid;
    logic        issue_ready, issue_fire, hazard, err_underflow;
    logic [14:0] busy_mask;
    logic [5:0]  inflight;

    int checks = 0;
    int errors = 0;

    reg_scoreboard #(.NUM_REGS(15), .CNT_W(2), .TOT_W(6)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
        .src1(src1), .src2(src2), .src1_valid(src1_valid), .src2_valid(src2_valid),
        .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
        .issue_ready(issue_ready), .issue_fire(issue_fire), .hazard(hazard),
        .busy_mask(busy_mask), .inflight(inflight), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv, iwb;
        logic [3:0]  idest;
        logic [3:0]  s1;
        logic        s1v;
        logic [3:0]  s2;
        logic        s2v;
        logic        fl, wbe;
        logic [3:0]  wbd;
        logic        e_haz, e_rdy, e_fire;
        logic [14:0] e_busy;
        logic [5:0]  e_infl;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic iwb, input logic [3:0] idest,
                       input logic [3:0] s1, input logic s1v,
                       input logic [3:0] s2, input logic s2v,
                       input logic fl, input logic wbe, input logic [3:0] wbd,
                       input logic e_haz, input logic e_rdy, input logic e_fire,
                       input logic [14:0] e_busy, input logic [5:0] e_infl,
                       input logic e_err);
        vec_t v;
        v.iv = iv; v.iwb = iwb; v.idest = idest; v.s1 = s1; v.s1v = s1v;
        v.s2 = s2; v.s2v = s2v; v.fl = fl; v.wbe = wbe; v.wbd = wbd;
        v.e_haz = e_haz; v.e_rdy = e_rdy; v.e_fire = e_fire;
        v.e_busy = e_busy; v.e_infl = e_infl; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; issue_wb_en = v.iwb; issue_dest = v.idest;
        src1 = v.s1; src1_valid = v.s1v; src2 = v.s2; src2_valid = v.s2v;
        flush = v.fl; wb_en = v.wbe; wb_dest = v.wbd;
    endtask

    task automatic idle();
        issue_valid = 0; issue_wb_en = 0; issue_dest = 0;
        src1 = 0; src1_valid = 0; src2 = 0; src2_valid = 0;
        flush = 0; wb_en = 0; wb_dest = 0;
    endtask

    initial begin
        //   iv iwb dst s1 s1v s2 s2v fl wbe wbd | haz rdy fire busy       infl err
        // RAW stall on r3, released by same-cycle WB
        add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 15'h0000, 0, 0);
        add(1, 1, 3,  0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 15'h0000, 0, 0);
        add(1, 1, 8,  3, 1, 0, 0, 0, 0, 0,   1, 0, 0, 15'h0008, 1, 0);
        add(1, 1, 8,  3, 1, 0, 0, 0, 0, 0,   1, 0, 0, 15'h0008, 1, 0);
        add(1, 1, 8,  3, 1, 0, 0, 0, 1, 3,   0, 1, 1, 15'h0008, 1, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 15'h0100, 1, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 1, 8,   0, 1, 0, 15'h0100, 1, 0);
        // three writers to r5, fourth saturates, then fires with a WB of r5
        add(1, 1, 5,  0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 15'h0000, 0, 0);
        add(1, 1, 5,  0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 15'h0020, 1, 0);
        add(1, 1, 5,  0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 15'h0020, 2, 0);
        add(1, 1, 5,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 15'h0020, 3, 0);
        add(1, 1, 5,  0, 0, 0, 0, 0, 1, 5,   0, 1, 1, 15'h0020, 3, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 15'h0020, 3, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 1, 5,   0, 1, 0, 15'h0020, 3, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 1, 5,   0, 1, 0, 15'h0020, 2, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 1, 5,   0, 1, 0, 15'h0020, 1, 0);
        // simultaneous alloc/retire on r2 with count 1
        add(1, 1, 2,  0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 15'h0000, 0, 0);
        add(1, 1, 2,  0, 0, 0, 0, 0, 1, 2,   0, 1, 1, 15'h0004, 1, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 15'h0004, 1, 0);
        // flush of a write to r7; src2 hazard on r2; WB clears r2
        add(1, 1, 7,  0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 15'h0004, 1, 0);
        add(0, 0, 0,  0, 0, 2, 1, 0, 0, 0,   1, 0, 0, 15'h0004, 1, 0);
        add(0, 0, 0,  2, 1, 0, 0, 0, 1, 2,   0, 1, 0, 15'h0004, 1, 0);
        // PC as dest and sources: no alloc, no hazard; WB of PC is ignored
        add(1, 1, 15, 15, 1, 15, 1, 0, 0, 0, 0, 1, 1, 15'h0000, 0, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 1, 15,  0, 1, 0, 15'h0000, 0, 0);
        // underflow on r4, sticky afterwards
        add(0, 0, 0,  0, 0, 0, 0, 0, 1, 4,   0, 1, 0, 15'h0000, 0, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 15'h0000, 0, 1);
        add(1, 1, 9,  0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 15'h0000, 0, 1);
        add(0, 0, 0,  9, 1, 0, 0, 0, 0, 0,   1, 0, 0, 15'h0200, 1, 1);

        idle();
        rst = 1'b1;
        #2;
        chk("reset_busy", 32'(busy_mask), 32'h0);
        chk("reset_inflight", 32'(inflight), 32'h0);
        chk("reset_ready", 32'(issue_ready), 32'h1);
        chk("reset_err", 32'(err_underflow), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_hazard", i), 32'(hazard), 32'(vecs[i].e_haz));
            chk($sformatf("v%0d_ready", i), 32'(issue_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_fire", i), 32'(issue_fire), 32'(vecs[i].e_fire));
            chk($sformatf("v%0d_busy", i), 32'(busy_mask), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d_inflight", i), 32'(inflight), 32'(vecs[i].e_infl));
            chk($sformatf("v%0d_err", i), 32'(err_underflow), 32'(vecs[i].e_err));
            @(negedge clk);
        end

        // Asynchronous reset between edges while r9 is pending and src1=r9 reads it
        #2;
        rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy_mask), 32'h0);
        chk("async_inflight", 32'(inflight), 32'h0);
        chk("async_err", 32'(err_underflow), 32'h0);
        chk("async_hazard", 32'(hazard), 32'h0);
        chk("async_ready", 32'(issue_ready), 32'h1);
        rst = 1'b0;
        @(negedge clk);

        // Stale WB of the pre-reset r9 write now underflows
        idle();
        wb_en = 1'b1;
        wb_dest = 4'd9;
        @(negedge clk);
        idle();
        #1;
        chk("stale_wb_err", 32'(err_underflow), 32'h1);
        chk("stale_wb_busy", 32'(busy_mask), 32'h0);
        chk("stale_wb_inflight", 32'(inflight), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Per-register pending-write scoreboard that sits beside the register file at the ID stage of the ARM pipeline. It counts in-flight writes to each architectural register, stalls issue of any instruction whose source operand has an outstanding write, and retires entries when the WB stage writes the register file. It exploits the register file's negedge write: a source retiring in the current cycle is not a hazard.

## Interface
- NUM_REGS, 15, tracked registers r0..r(NUM_REGS-1); index 15 (PC) is never tracked
- CNT_W, 2, per-register pending counter width; max pending per register = 2^CNT_W-1
- TOT_W, 6, width of total in-flight counter
- clk  in  1  system clock, posedge state updates
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  ID has an instruction to issue
- issue_wb_en  in  1  issuing instruction writes a register
- issue_dest  in  4  destination register of issuing instruction
- src1, src2  in  4 each  source register indices
- src1_valid, src2_valid  in  1 each  source is actually read
- flush  in  1  squash the instruction in ID this cycle (branch taken)
- wb_en  in  1  WB stage writes register file this cycle
- wb_dest  in  4  WB destination
- issue_ready  out  1  instruction may issue (no hazard, no saturation)
- issue_fire  out  1  issue_valid & issue_ready & !flush
- hazard  out  1  a valid source has a pending write
- busy_mask  out  NUM_REGS  bit r = 1 when count[r] != 0 (registered view)
- inflight  out  TOT_W  total pending writes across all registers
- err_underflow  out  1  sticky: WB retired a register with count 0

## Operation
- State: count[r] (CNT_W bits) per tracked register, inflight, err_underflow.
- ret[r] = wb_en & wb_dest==r & r<NUM_REGS & count[r]!=0.
- eff[r] = count[r] - ret[r] (combinational, same cycle).
- hazard = (src1_valid & src1<NUM_REGS & eff[src1]!=0) | (src2_valid & src2<NUM_REGS & eff[src2]!=0).
- sat = issue_wb_en & issue_dest<NUM_REGS & eff[issue_dest]==2^CNT_W-1.
- issue_ready = !hazard & !sat; independent of issue_valid and flush.
- alloc[r] = issue_fire & issue_wb_en & issue_dest==r & r<NUM_REGS.
- count[r] <= count[r] + alloc[r] - ret[r]; alloc and ret on same register same cycle: unchanged.
- inflight <= inflight + (any alloc) - (any ret); never wraps (bounded by NUM_REGS*(2^CNT_W-1) < 2^TOT_W).
- wb_en with wb_dest<NUM_REGS and count[wb_dest]==0: err_underflow <= 1, counts unchanged. wb_dest==15: ignored, no error.
- issue_dest==15 or sources ==15: never allocate, never hazard.
- flush: suppresses issue_fire; already-allocated entries are unaffected (they retire via WB normally).
- err_underflow clears only on rst.

## Timing
- Reset (async, immediate): all count=0, inflight=0, err_underflow=0, busy_mask=0; hence hazard=0, issue_ready=1.
- hazard/issue_ready/issue_fire: combinational from current state and inputs, zero latency.
- Allocation visible in busy_mask/hazard the cycle after issue_fire.
- Retirement: source unblocks in the same cycle WB writes it (negedge register file write precedes next posedge read).
- rst asserted mid-operation discards all pending state; WB of pre-reset instructions afterward sets err_underflow (pipeline must be reset together).

## Test plan
- Reset: assert rst async between edges -> busy_mask=0, inflight=0, issue_ready=1 immediately.
- RAW stall: issue dest=r3 cycle 0; cycle 1 issue src1=r3 -> hazard=1, issue_ready=0; wb_en, wb_dest=3 at cycle 3 -> issue_ready=1 in cycle 3, busy_mask[3]=0 cycle 4.
- Multiple writers: three issues to r5 -> count=3, fourth issue to r5 stalls (sat); one WB r5 same cycle -> fourth fires, count stays 3.
- Simultaneous alloc/retire on r2 with count=1 -> count stays 1, inflight unchanged.
- Flush: issue_valid=1, flush=1, dest=r7 -> issue_fire=0, busy_mask[7]=0 next cycle.
- Error/PC: wb_en, wb_dest=4 with count 0 -> err_underflow=1 sticky until rst; issue dest=15 or src=15 -> no allocation, no hazard.
